// File: rtl/bt_cmd_rx_if.sv
// bt_cmd_rx_if: command-decoder outputs of the Bluetooth UART receiver.
//   RXD_DATA  [7:0] last correctly framed byte
//   RXD_VALID       one-cycle pulse, new byte in RXD_DATA
//   FRAME_ERR       one-cycle pulse, stop bit sampled low
//   TRACK     [2:0] current track index
//   VOL_UP          one-cycle volume-up pulse
//   VOL_DOWN        one-cycle volume-down pulse
// master = receiver (drives), slave = playback controller / debug (reads).
interface bt_cmd_rx_if;
  logic [7:0] RXD_DATA;
  logic       RXD_VALID;
  logic       FRAME_ERR;
  logic [2:0] TRACK;
  logic       VOL_UP;
  logic       VOL_DOWN;

  modport master (output RXD_DATA, RXD_VALID, FRAME_ERR, TRACK, VOL_UP, VOL_DOWN);
  modport slave  (input  RXD_DATA, RXD_VALID, FRAME_ERR, TRACK, VOL_UP, VOL_DOWN);
endinterface

// File: rtl/bt_cmd_rx.sv
// bt_cmd_rx: 8N1 UART receiver plus single-byte command decoder feeding the
// MP3 playback controller.
//   CLK       system clock, rising edge
//   RST       asynchronous active-low reset
//   UART_RXD  serial input, idle high, LSB first, asynchronous to CLK
//   cmd       bt_cmd_rx_if.master: byte/valid/frame-error, TRACK, VOL pulses
// Commands: '0'..'0'+TRACK_NUM-1 select track, 'N' next, 'P' previous
// (both wrap), 'U' volume up, 'D' volume down; other bytes only update
// RXD_DATA. CLK_FREQ/BAUD must be >= 4 and TRACK_NUM <= 8.
module bt_cmd_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 9600,
  parameter int TRACK_NUM = 7
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         UART_RXD,
  bt_cmd_rx_if.master  cmd
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rxd_meta, rxd_sync, rxd_dly;
  logic          fall;
  logic [2:0]    track_nxt;
  logic          is_up, is_dn;

  // Two-flop synchronizer plus one delayed copy for edge detection. Reset
  // to 1 so a line that is idle at reset release does not look like a start.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_dly  <= 1'b1;
    end else begin
      rxd_meta <= UART_RXD;
      rxd_sync <= rxd_meta;
      rxd_dly  <= rxd_sync;
    end
  end

  assign fall = rxd_dly & ~rxd_sync;

  // Command decode of the completed shift register; only committed in the
  // cycle the stop bit is accepted.
  always_comb begin
    track_nxt = cmd.TRACK;
    is_up     = 1'b0;
    is_dn     = 1'b0;
    if (shreg >= 8'h30 && shreg < 8'(8'h30 + TRACK_NUM))
      track_nxt = 3'(shreg - 8'h30);
    else if (shreg == 8'h4E)
      track_nxt = (cmd.TRACK == 3'(TRACK_NUM - 1)) ? 3'd0 : cmd.TRACK + 3'd1;
    else if (shreg == 8'h50)
      track_nxt = (cmd.TRACK == 3'd0) ? 3'(TRACK_NUM - 1) : cmd.TRACK - 3'd1;
    else if (shreg == 8'h55)
      is_up = 1'b1;
    else if (shreg == 8'h44)
      is_dn = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      cmd.RXD_DATA  <= '0;
      cmd.RXD_VALID <= 1'b0;
      cmd.FRAME_ERR <= 1'b0;
      cmd.TRACK     <= '0;
      cmd.VOL_UP    <= 1'b0;
      cmd.VOL_DOWN  <= 1'b0;
    end else begin
      cmd.RXD_VALID <= 1'b0;
      cmd.FRAME_ERR <= 1'b0;
      cmd.VOL_UP    <= 1'b0;
      cmd.VOL_DOWN  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        // Re-check the start bit at its middle; a high line means a glitch.
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxd_sync ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxd_sync;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Leaving at mid-stop-bit gives half a bit of slack for a
        // back-to-back start edge.
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rxd_sync) begin
              cmd.RXD_DATA  <= shreg;
              cmd.RXD_VALID <= 1'b1;
              cmd.TRACK     <= track_nxt;
              cmd.VOL_UP    <= is_up;
              cmd.VOL_DOWN  <= is_dn;
              state         <= S_IDLE;
            end else begin
              cmd.FRAME_ERR <= 1'b1;
              state         <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Hold off until the line returns high so a stuck-low line yields
        // exactly one frame error.
        S_BREAK: begin
          if (rxd_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bt_cmd_rx.sv
module tb_bt_cmd_rx;
  localparam int DIV = 16;
  localparam int TN  = 7;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic UART_RXD = 1'b1;

  bt_cmd_rx_if ifc ();

  bt_cmd_rx #(.CLK_FREQ(16), .BAUD(1), .TRACK_NUM(TN)) dut (
    .CLK(CLK), .RST(RST), .UART_RXD(UART_RXD), .cmd(ifc.master)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0, errors = 0;

  // Monitor: counts high cycles of each pulse output (a widened pulse
  // therefore shows up as an extra count), illegal overlaps and TRACK
  // changes outside a RXD_VALID cycle.
  int n_vld = 0, n_up = 0, n_dn = 0, n_ferr = 0, n_both = 0, n_badtrk = 0;
  int t_vld = 0, t_start = 0;
  logic [2:0] prev_trk = 3'd0;
  always @(negedge CLK) begin
    if (!RST) begin
      prev_trk = ifc.TRACK;
    end else begin
      if (ifc.RXD_VALID) begin n_vld++; t_vld = cyc; end
      if (ifc.VOL_UP)    n_up++;
      if (ifc.VOL_DOWN)  n_dn++;
      if (ifc.FRAME_ERR) n_ferr++;
      if (ifc.VOL_UP && ifc.VOL_DOWN) n_both++;
      if (ifc.TRACK !== prev_trk && !ifc.RXD_VALID) n_badtrk++;
      prev_trk = ifc.TRACK;
    end
  end

  // Reference model: command semantics in plain arithmetic.
  int m_track = 0, m_data = 0, m_vld = 0, m_up = 0, m_dn = 0;
  task automatic model_byte(input logic [7:0] b);
    m_data = int'(b);
    m_vld++;
    if (b >= 8'h30 && int'(b) < 8'h30 + TN) m_track = int'(b) - 8'h30;
    else if (b == 8'h4E) m_track = (m_track + 1) % TN;
    else if (b == 8'h50) m_track = (m_track + TN - 1) % TN;
    else if (b == 8'h55) m_up++;
    else if (b == 8'h44) m_dn++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One frame; when stop_hi is 0 the line stays low for `hold` cycles
  // from the start of the stop bit.
  task automatic send_byte(input logic [7:0] b, input bit stop_hi, input int hold, input int gap);
    UART_RXD = 1'b0;
    t_start  = cyc;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      UART_RXD = b[i];
      tick(DIV);
    end
    UART_RXD = stop_hi;
    tick(stop_hi ? DIV : hold);
    UART_RXD = 1'b1;
    if (stop_hi) model_byte(b);
    if (gap > 0) tick(gap);
  endtask

  int s_vld, s_up, s_dn, s_ferr;
  task automatic snap();
    s_vld = n_vld; s_up = n_up; s_dn = n_dn; s_ferr = n_ferr;
  endtask

  typedef struct {
    logic [7:0] b;
    int         gap;
    logic [7:0] exp_data;
    logic [2:0] exp_track;
    int         d_up;
    int         d_dn;
  } vec_t;

  vec_t tbl[10];
  logic [7:0] cmds[11];

  initial begin
    tbl[0] = '{8'h33,  5, 8'h33, 3'd3, 0, 0};
    tbl[1] = '{8'h36,  5, 8'h36, 3'd6, 0, 0};
    tbl[2] = '{8'h4E,  5, 8'h4E, 3'd0, 0, 0};  // next wraps 6 -> 0
    tbl[3] = '{8'h50,  5, 8'h50, 3'd6, 0, 0};  // prev wraps 0 -> 6
    tbl[4] = '{8'h36,  5, 8'h36, 3'd6, 0, 0};  // reselect current track
    tbl[5] = '{8'h55,  0, 8'h55, 3'd6, 1, 0};  // U D U back-to-back
    tbl[6] = '{8'h44,  0, 8'h44, 3'd6, 0, 1};
    tbl[7] = '{8'h55,  5, 8'h55, 3'd6, 1, 0};
    tbl[8] = '{8'h37,  5, 8'h37, 3'd6, 0, 0};  // just past the track range
    tbl[9] = '{8'h41,  5, 8'h41, 3'd6, 0, 0};
    cmds = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
             8'h4E, 8'h50, 8'h55, 8'h44};

    // Reset state
    #2 RST = 1'b0;
    tick(3);
    chk("rst_data",  int'(ifc.RXD_DATA), 0);
    chk("rst_track", int'(ifc.TRACK), 0);
    chk("rst_valid", int'(ifc.RXD_VALID), 0);
    chk("rst_ferr",  int'(ifc.FRAME_ERR), 0);
    chk("rst_up",    int'(ifc.VOL_UP), 0);
    chk("rst_dn",    int'(ifc.VOL_DOWN), 0);
    RST = 1'b1;
    tick(5);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      snap();
      send_byte(tbl[i].b, 1'b1, 0, tbl[i].gap);
      chk($sformatf("tbl%0d_data", i),  int'(ifc.RXD_DATA), int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_track", i), int'(ifc.TRACK), int'(tbl[i].exp_track));
      chk($sformatf("tbl%0d_vld", i),   n_vld - s_vld, 1);
      chk($sformatf("tbl%0d_up", i),    n_up - s_up, tbl[i].d_up);
      chk($sformatf("tbl%0d_dn", i),    n_dn - s_dn, tbl[i].d_dn);
      chk($sformatf("tbl%0d_ferr", i),  n_ferr - s_ferr, 0);
      chk_rng($sformatf("tbl%0d_latency", i), t_vld - t_start, 153, 155);
    end

    // Framing error with the line held low 40 cycles
    snap();
    send_byte(8'h32, 1'b0, 40, 10);
    chk("ferr_cnt",   n_ferr - s_ferr, 1);
    chk("ferr_vld",   n_vld - s_vld, 0);
    chk("ferr_track", int'(ifc.TRACK), 6);
    chk("ferr_data",  int'(ifc.RXD_DATA), 8'h41);
    snap();
    send_byte(8'h31, 1'b1, 0, 5);
    chk("post_ferr_track", int'(ifc.TRACK), 1);
    chk("post_ferr_data",  int'(ifc.RXD_DATA), 8'h31);
    chk("post_ferr_vld",   n_vld - s_vld, 1);

    // 3-cycle glitch on the idle line
    snap();
    UART_RXD = 1'b0;
    tick(3);
    UART_RXD = 1'b1;
    tick(40);
    chk("glitch_vld",  n_vld - s_vld, 0);
    chk("glitch_ferr", n_ferr - s_ferr, 0);
    chk("glitch_track", int'(ifc.TRACK), 1);
    send_byte(8'h4E, 1'b1, 0, 5);
    chk("post_glitch_track", int'(ifc.TRACK), 2);

    // Reset in the middle of the data bits of 0x35
    snap();
    UART_RXD = 1'b0;
    tick(DIV);
    for (int i = 0; i < 3; i++) begin
      UART_RXD = 1'(8'h35 >> i);
      tick(DIV);
    end
    RST = 1'b0;
    #1;
    chk("midrst_data",  int'(ifc.RXD_DATA), 0);
    chk("midrst_track", int'(ifc.TRACK), 0);
    chk("midrst_valid", int'(ifc.RXD_VALID), 0);
    chk("midrst_up",    int'(ifc.VOL_UP) + int'(ifc.VOL_DOWN) + int'(ifc.FRAME_ERR), 0);
    m_track = 0; m_data = 0;
    UART_RXD = 1'b1;
    tick(3);
    RST = 1'b1;
    tick(200);
    chk("midrst_nopulse", (n_vld - s_vld) + (n_ferr - s_ferr), 0);
    send_byte(8'h34, 1'b1, 0, 5);
    chk("post_rst_track", int'(ifc.TRACK), 4);
    chk("post_rst_data",  int'(ifc.RXD_DATA), 8'h34);

    // Randomized bytes and gaps against the model
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      if ($urandom_range(0, 9) < 8) b = cmds[$urandom_range(0, 10)];
      else                          b = 8'($urandom);
      send_byte(b, 1'b1, 0, int'($urandom_range(0, 20)));
      chk($sformatf("rnd%0d_data", i),  int'(ifc.RXD_DATA), m_data);
      chk($sformatf("rnd%0d_track", i), int'(ifc.TRACK), m_track);
      chk($sformatf("rnd%0d_up", i),    n_up, m_up);
      chk($sformatf("rnd%0d_dn", i),    n_dn, m_dn);
      chk($sformatf("rnd%0d_vld", i),   n_vld, m_vld);
    end

    tick(20);
    chk("vol_overlap",   n_both, 0);
    chk("track_glitch",  n_badtrk, 0);
    chk("total_ferr",    n_ferr, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
- UART receiver plus command decoder for the Bluetooth serial module.
- Sits directly upstream of the MP3 playback controller.
- Turns single-byte commands on UART_RXD into:
  - a track-select index (0..TRACK_NUM-1), which the playback controller compares against its previous value to trigger a decoder reset and restart;
  - one-cycle volume up/down pulses, which feed the volume register.
- Exposes the last received byte for LED debug.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate; DIV = CLK_FREQ/BAUD (integer division, must be >= 4).
- TRACK_NUM, 7, number of selectable tracks; TRACK resets to 0 and wraps within 0..TRACK_NUM-1.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous active-low reset.
- UART_RXD  in  1  serial input from Bluetooth module, idle high, 8N1, LSB first; asynchronous to CLK.
- RXD_DATA  out  8  last correctly framed byte.
- RXD_VALID  out  1  one-cycle pulse, new byte in RXD_DATA.
- FRAME_ERR  out  1  one-cycle pulse, stop bit sampled low.
- TRACK  out  3  current track index.
- VOL_UP  out  1  one-cycle pulse per volume-up command.
- VOL_DOWN  out  1  one-cycle pulse per volume-down command.

Behaviour:
- Reset (RST low, asynchronous):
  - RXD_DATA=0, TRACK=0; RXD_VALID, FRAME_ERR, VOL_UP, VOL_DOWN=0.
  - FSM to IDLE, counters cleared, synchronizer flops set to 1.
  - Reset mid-byte discards the partial byte; no pulse is emitted.
- Input conditioning: UART_RXD passes through a 2-flop synchronizer (reset value 1). A falling edge is detected on the synchronized signal vs. its registered copy.
- FSM states:
  - IDLE: on falling edge -> START with baud counter cleared.
  - START: count to DIV/2-1, then sample. Line low -> DATA (bit index 0, counter cleared). Line high -> IDLE (glitch; no output).
  - DATA: every DIV cycles, sample the line into shift register bit [index], LSB first. After bit 7 -> STOP.
  - STOP: after DIV cycles, sample the line.
    - High: RXD_DATA <= shift register, RXD_VALID=1 for one cycle, decode (below), -> IDLE.
    - Low: FRAME_ERR=1 for one cycle, byte discarded (RXD_DATA and TRACK unchanged), -> BREAK.
  - BREAK: wait until the synchronized line is high, then -> IDLE. A continuous low line produces exactly one FRAME_ERR.
- Latency: sampling point is mid-bit. RXD_VALID rises 2 (sync) + DIV/2 + 9*DIV cycles (±1) after the start-bit falling edge on the pin.
- Decode happens in the RXD_VALID cycle; TRACK update and VOL pulses coincide with RXD_VALID:
  - 0x30..0x30+TRACK_NUM-1 ('0'..'6'): TRACK <= byte-0x30.
  - 0x4E 'N': TRACK <= TRACK+1; TRACK_NUM-1 wraps to 0.
  - 0x50 'P': TRACK <= TRACK-1; 0 wraps to TRACK_NUM-1.
  - 0x55 'U': VOL_UP pulse.
  - 0x44 'D': VOL_DOWN pulse.
  - Any other byte: RXD_VALID and RXD_DATA update only; TRACK, VOL unchanged.
- Selecting the already-current track leaves TRACK unchanged, so downstream sees no change and does not restart.
- VOL_UP and VOL_DOWN are never high together; successive pulses are at least 10*DIV cycles apart.
- A falling edge arriving while in START/DATA/STOP is ignored; only the FSM's own sampling matters.
- Back-to-back bytes (stop bit immediately followed by start bit) must be received without loss. IDLE is re-entered at mid-stop-bit, before the next falling edge.

Test Plan:
- Sim with CLK_FREQ=16, BAUD=1 (DIV=16). Send 0x33 -> RXD_VALID one pulse; RXD_DATA=0x33, TRACK=3; VOL pulses stay 0.
- TRACK=6, send 'N' (0x4E) -> TRACK=0. Then send 'P' (0x50) -> TRACK=6. RXD_DATA=0x50 at end.
- Send 'U', 'D', 'U' back-to-back with no idle gap -> exactly two VOL_UP and one VOL_DOWN pulse, each one cycle wide. Three RXD_VALID pulses in order.
- Send 0x37 and 0x41 -> RXD_VALID pulses, RXD_DATA=0x41, TRACK unchanged.
- Stop bit forced low for 0x32, line held low 40 cycles, then released -> one FRAME_ERR, no RXD_VALID, TRACK unchanged. Next byte 0x31 is received correctly, TRACK=1.
- 3-cycle low glitch on idle line -> no pulses, FSM back in IDLE.
- Deassert-assert RST during DATA of byte 0x35 -> all outputs 0 and TRACK=0 immediately. No pulse for the aborted byte; the next full frame 0x34 gives TRACK=4.
